fsm1_arb: RTL and testbench



---
 rtl/fsm1_arb_pkg.sv | 18 +
 rtl/fsm1_arb_rr_pick.sv | 28 ++
 rtl/fsm1_arb.sv | 135 +++++++++++++
 tb/tb_fsm1_arb.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fsm1_arb_pkg.sv
// Shared types for the fsm1 read-engine arbiter.
// State encoding and index-width helper.
package fsm1_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        // Never reached legally; lets X-propagation flag a corrupted state.
        S_XXX   = 3'd7
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsm1_arb_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational so other arbiters can reuse it.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   winner
);

    int idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fsm1_arb.sv
// Round-robin arbiter sharing one fsm1 read engine among NREQ requesters.
// Issues go, waits for ds, returns done or a watchdog err per requester.
module fsm1_arb
    import fsm1_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         err,
    output logic                    go,
    input  logic                    ds,
    output logic                    busy
);

    localparam int IW = idx_w(NREQ);
    localparam int TW = idx_w(TIMEOUT + 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic            go_q, go_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            any;
    logic [IW-1:0]   winner;
    logic            tmo;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (any),
        .winner (winner)
    );

    assign tmo = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (ds)       state_d = S_IDLE;
                else if (tmo) state_d = S_DRAIN;
            end
            S_DRAIN: if (ds) state_d = S_IDLE;
            default: state_d = S_XXX;
        endcase
    end

    always_comb begin
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        go_d    = 1'b0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (any) begin
                    go_d    = 1'b1;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                    owner_d = winner;
                    ptr_d   = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            S_ISSUE: timer_d = '0;
            S_WAIT: begin
                // ds has priority over a timeout landing in the same cycle.
                if (ds) begin
                    done_d[owner_q] = 1'b1;
                    gnt_d           = '0;
                end else if (tmo) begin
                    err_d[owner_q] = 1'b1;
                    gnt_d          = '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DRAIN: gnt_d = '0;
            default: begin
                gnt_d   = 'x;
                done_d  = 'x;
                err_d   = 'x;
                go_d    = 1'bx;
                owner_d = 'x;
                ptr_d   = 'x;
                timer_d = 'x;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            go_q    <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            go_q    <= go_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign err   = err_q;
    assign go    = go_q;
    assign owner = owner_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_fsm1_arb.sv
// Randomised bench for fsm1_arb against a transaction-level model.
// The bench plays the engine, driving ds a chosen number of wait cycles after go.
module tb_fsm1_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       ds = 1'b0;
    logic [3:0] gnt, done, err;
    logic [1:0] owner;
    logic       go, busy;

    int n_vec = 0;
    int n_bad = 0;
    int mptr  = 0;

    fsm1_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .owner (owner),
        .done  (done),
        .err   (err),
        .go    (go),
        .ds    (ds),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pk(input logic b, input logic g,
                                       input logic [3:0] gn,
                                       input logic [3:0] d,
                                       input logic [3:0] e);
        return {18'b0, b, g, gn, d, e};
    endfunction

    function automatic logic [31:0] obs();
        return pk(busy, go, gnt, done, err);
    endfunction

    // Round-robin search from the model pointer, ascending with wrap.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // One transaction; ds arrives in wait cycle k (k > TIMEOUT means late).
    task automatic run_txn(input logic [3:0] r, input int k, input bit spur);
        int         w;
        logic [3:0] oh;
        req = r;
        ds  = 1'b0;
        tick();
        w  = pick(r, mptr);
        oh = 4'b0001 << w;
        chk("grant", obs(), pk(1, 1, oh, 0, 0));
        chk("owner", 32'(owner), 32'(w));
        mptr = (w + 1) % NREQ;
        if (spur) req[w] = 1'b0;
        ds = spur;
        tick();
        chk("issue", obs(), pk(1, 0, oh, 0, 0));
        for (int c = 1; c <= 64; c++) begin
            ds = (c == k);
            tick();
            if (c == k && c <= TIMEOUT) begin
                chk("done", obs(), pk(0, 0, 0, oh, 0));
                break;
            end else if (c == TIMEOUT) begin
                chk("err", obs(), pk(1, 0, 0, 0, oh));
                req = 4'b1111;
            end else if (c > TIMEOUT) begin
                if (c == k) begin
                    chk("drain_end", obs(), pk(0, 0, 0, 0, 0));
                    break;
                end
                chk("drain", obs(), pk(1, 0, 0, 0, 0));
            end else begin
                chk("wait", obs(), pk(1, 0, oh, 0, 0));
            end
        end
        ds = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        int         k;
        bit         sp;
        repeat (2) tick();
        chk("rst_out", obs(), pk(0, 0, 0, 0, 0));
        chk("rst_owner", 32'(owner), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle", obs(), pk(0, 0, 0, 0, 0));

        for (int t = 0; t < 5; t++) run_txn(4'b1111, 2, 1'b0);
        run_txn(4'b0001, 16, 1'b0);
        run_txn(4'b0010, 20, 1'b0);
        run_txn(4'b1000, 5, 1'b1);

        for (int t = 0; t < 80; t++) begin
            r = 4'($urandom_range(1, 15));
            case ($urandom % 5)
                0:       k = TIMEOUT;
                1:       k = $urandom_range(TIMEOUT + 1, TIMEOUT + 8);
                default: k = $urandom_range(1, TIMEOUT - 1);
            endcase
            sp = ($urandom % 3 == 0);
            run_txn(r, k, sp);
            if ($urandom % 4 == 0) begin
                req = '0;
                tick();
                chk("idle_noreq", obs(), pk(0, 0, 0, 0, 0));
            end
        end

        req = 4'b0010;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", obs(), pk(0, 0, 0, 0, 0));
        chk("rst_async_owner", 32'(owner), 32'd0);
        tick();
        rst_n = 1'b1;
        mptr  = 0;
        run_txn(4'b0100, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
